// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet controller and future framers:
// parser states, default sync marker and the checksum fold step.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DRAIN
    } pkt_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // One step of the running XOR checksum.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/uart_packet_ctrl_if.sv
// Payload stream from the packet controller to the BPSK transmit path.
interface uart_packet_ctrl_if #(
    parameter int MAX_LEN = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [7:0]       pkt_data;
    logic             pkt_valid;
    logic             pkt_ready;
    logic             pkt_last;
    logic [LEN_W-1:0] pkt_len;

    modport master (output pkt_data, output pkt_valid, output pkt_last, output pkt_len,
                    input pkt_ready);
    modport slave  (input pkt_data, input pkt_valid, input pkt_last, input pkt_len,
                    output pkt_ready);
endinterface

// File: rtl/pkt_buffer_ram.sv
// Payload buffer: register array with one synchronous write port and one
// combinational read port. Contents are not reset.
module pkt_buffer_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_packet_ctrl.sv
// Hunts for SYNC_BYTE, frames a length-prefixed XOR-checked packet into a
// local buffer and replays the validated payload over valid/ready.
module uart_packet_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 64
) (
    input  logic                      clk_baud,
    input  logic                      rst_n,
    input  logic [7:0]                uart_word,
    input  logic                      uart_ready,
    uart_packet_ctrl_if.master        pkt,
    output logic                      err_chk,
    output logic                      err_len,
    output logic                      err_timeout,
    output logic                      drop
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    pkt_state_t       state, state_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [IDX_W-1:0] wr_idx, wr_idx_n, rd_idx, rd_idx_n;
    logic [7:0]       xor_q, xor_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             we;
    logic [7:0]       rdata;
    logic [7:0]       data_q, data_n;
    logic             valid_q, valid_n, last_q, last_n;
    logic             err_chk_n, err_len_n, err_to_n, drop_n;

    pkt_buffer_ram #(.DEPTH(MAX_LEN), .ADDR_W(IDX_W)) u_buf (
        .clk   (clk_baud),
        .we    (we),
        .waddr (wr_idx),
        .wdata (uart_word),
        .raddr (rd_idx_n),
        .rdata (rdata)
    );

    always_ff @(posedge clk_baud) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            xor_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            drop        <= 1'b0;
        end else begin
            state       <= state_n;
            len_q       <= len_n;
            wr_idx      <= wr_idx_n;
            rd_idx      <= rd_idx_n;
            xor_q       <= xor_n;
            cnt_q       <= cnt_n;
            data_q      <= data_n;
            valid_q     <= valid_n;
            last_q      <= last_n;
            err_chk     <= err_chk_n;
            err_len     <= err_len_n;
            err_timeout <= err_to_n;
            drop        <= drop_n;
        end
    end

    always_comb begin
        state_n   = state;
        len_n     = len_q;
        wr_idx_n  = wr_idx;
        rd_idx_n  = rd_idx;
        xor_n     = xor_q;
        cnt_n     = '0;
        we        = 1'b0;
        err_chk_n = 1'b0;
        err_len_n = 1'b0;
        err_to_n  = 1'b0;
        drop_n    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (uart_ready && uart_word == SYNC_BYTE) begin
                    state_n = ST_LEN;
                end
            end
            ST_LEN: begin
                if (uart_ready) begin
                    if (uart_word >= 8'd1 && uart_word <= 8'(MAX_LEN)) begin
                        len_n    = LEN_W'(uart_word);
                        xor_n    = uart_word;
                        wr_idx_n = '0;
                        state_n  = ST_PAYLOAD;
                    end else begin
                        err_len_n = 1'b1;
                        state_n   = ST_IDLE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (uart_ready) begin
                    we       = 1'b1;
                    xor_n    = xor_fold(xor_q, uart_word);
                    wr_idx_n = wr_idx + IDX_W'(1);
                    if (LEN_W'(wr_idx) == len_q - LEN_W'(1)) begin
                        state_n = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (uart_ready) begin
                    if (uart_word == xor_q) begin
                        rd_idx_n = '0;
                        state_n  = ST_DRAIN;
                    end else begin
                        err_chk_n = 1'b1;
                        state_n   = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                drop_n = uart_ready;
                if (valid_q && pkt.pkt_ready) begin
                    rd_idx_n = rd_idx + IDX_W'(1);
                    if (last_q) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Inter-byte watchdog; an arriving byte always beats expiry.
        if (state == ST_LEN || state == ST_PAYLOAD || state == ST_CHECK) begin
            if (uart_ready) begin
                cnt_n = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                err_to_n = 1'b1;
                state_n  = ST_IDLE;
            end else begin
                cnt_n = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        valid_n = (state_n == ST_DRAIN);
        last_n  = valid_n && (LEN_W'(rd_idx_n) == len_n - LEN_W'(1));
        data_n  = valid_n ? rdata : 8'h00;
    end

    assign pkt.pkt_data  = data_q;
    assign pkt.pkt_valid = valid_q;
    assign pkt.pkt_last  = last_q;
    assign pkt.pkt_len   = len_q;
endmodule

// File: doc/uart_packet_ctrl.md
# uart_packet_ctrl

Packet-level controller downstream of the UART byte deserializer. It consumes the one-cycle `uart_ready` pulses with their `uart_word` bytes and hunts for a sync byte. It then frames a length-prefixed, XOR-checksummed packet into a local buffer and replays the validated payload to the BPSK transmit path over a valid/ready handshake. Corrupt, oversize or stalled packets are discarded and flagged.

## Interface
- `SYNC_BYTE`, 8'hA5, start-of-packet marker.
- `MAX_LEN`, 16, maximum payload bytes (1..255).
- `TIMEOUT`, 64, max `clk_baud` cycles allowed between consecutive bytes of one packet.
- `clk_baud` input 1: the block's only clock, baud-synchronous.
- `rst_n` input 1: reset, synchronous, active-low.
- `uart_word` input 8: byte from the deserializer; valid only when `uart_ready`=1.
- `uart_ready` input 1: single-cycle byte strobe.
- `pkt_data` output 8: payload byte.
- `pkt_valid` output 1: `pkt_data` valid.
- `pkt_ready` input 1: downstream accepts.
- `pkt_last` output 1: final payload byte.
- `pkt_len` output $clog2(MAX_LEN+1): payload length, held stable while draining.
- `err_chk` output 1: one-cycle pulse on checksum mismatch.
- `err_len` output 1: one-cycle pulse on length 0 or length > MAX_LEN.
- `err_timeout` output 1: one-cycle pulse on inter-byte timeout.
- `drop` output 1: one-cycle pulse for a byte received during DRAIN.

## Operation
- Frame: SYNC_BYTE, LEN, LEN payload bytes, CHK. CHK = LEN ^ payload[0] ^ … ^ payload[LEN-1].
- States: IDLE, LEN, PAYLOAD, CHECK, DRAIN.
- IDLE: non-sync bytes are ignored silently. A sync byte moves to LEN.
- LEN: a byte in 1..MAX_LEN latches `pkt_len`, seeds the running XOR, clears the write index and moves to PAYLOAD. Any other value pulses `err_len` and returns to IDLE.
- PAYLOAD: each byte is written to buffer[wr_idx] and XOR-accumulated. After byte LEN-1 the state moves to CHECK.
- CHECK: a byte equal to the running XOR moves to DRAIN with rd_idx=0. A mismatch pulses `err_chk` and returns to IDLE.
- Timeout counter: cleared on every accepted byte, counts in LEN/PAYLOAD/CHECK. When it reaches TIMEOUT-1 without a byte, `err_timeout` pulses and the state returns to IDLE. A byte and expiry in the same cycle: the byte wins and the counter clears.
- DRAIN:
  - `pkt_valid`=1 and `pkt_data`=buffer[rd_idx].
  - `pkt_last`=(rd_idx==pkt_len-1).
  - Each `pkt_valid & pkt_ready` increments rd_idx.
  - The handshake on the last byte returns to IDLE.
  - Incoming bytes are discarded with a `drop` pulse; sync hunting resumes only in IDLE.
- Reset values: all outputs 0, state IDLE, indices/counters/XOR 0. Buffer contents are don't-care. `rst_n` low mid-packet or mid-drain aborts with no error pulse.

## Timing
- Inputs are sampled at posedge `clk_baud`; all outputs are registered.
- CHK byte strobed at cycle t -> `pkt_valid`=1 with payload[0] at t+1.
- With `pkt_ready` held at 1: one byte per cycle, so LEN bytes occupy t+1..t+LEN, `pkt_valid` falls at t+LEN+1, and IDLE is reached at t+LEN+1.
- `pkt_data`, `pkt_last` and `pkt_len` are stable while `pkt_valid`=1 and `pkt_ready`=0.
- Error pulses are asserted the cycle after the offending byte (or expiry) and last exactly one cycle.
- A sync byte strobed on the cycle IDLE is re-entered is honoured.

## Structure
- Shared package `uart_pkg`:
  - state enum `pkt_state_t`;
  - default SYNC_BYTE constant;
  - function `xor_fold` for checksum accumulation, reusable by a future transmit-side framer.
- Sub-module `pkt_buffer_ram`: MAX_LEN×8 register array, one synchronous write port and one combinational read port indexed by rd_idx.

## Test plan
- Frame A5 03 11 22 33 (CHK 03^11^22^33=03) -> `pkt_valid` next cycle; bytes 11, 22, 33 with `pkt_last` on 33; `pkt_len`=3; no error pulses.
- Same frame with CHK=04 -> `err_chk` one pulse, `pkt_valid` never asserted, next valid frame accepted normally.
- LEN=00, then separately LEN=17 with MAX_LEN=16 -> `err_len` pulse each time, return to IDLE.
- A5 02 11 followed by 64 idle cycles -> `err_timeout` pulse on the 64th cycle; a subsequent full frame succeeds.
- Valid 2-byte frame with `pkt_ready` toggling 0,1,0,0,1 -> each byte held stable until its handshake; during drain a strobed byte 5A yields one `drop` pulse and no state change.
- `rst_n` low for one cycle mid-PAYLOAD and mid-DRAIN -> all outputs 0 the following cycle; a fresh frame then completes.
